// File: rtl/shift_pkg.sv
// Shared constants for the shift sequencer and the single-bit shift unit.
// Mode codes match the {s1,s0} select lines of the shift datapath.
// The FSM state encoding lives here so benches can decode it if needed.
package shift_pkg;

   localparam logic [1:0] MODE_LSR = 2'b00;  // logical right, MSB <= 0
   localparam logic [1:0] MODE_LSL = 2'b01;  // logical left, LSB <= 0
   localparam logic [1:0] MODE_ASR = 2'b10;  // arithmetic right, MSB kept
   localparam logic [1:0] MODE_ROL = 2'b11;  // rotate left, MSB -> LSB

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// Single-position shifter, purely combinational.
// Ports:
//   data_i  operand
//   mode_i  shift mode {s1,s0}
//   data_o  operand shifted by one position according to mode_i
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [1:0]       mode_i,
   output logic [WIDTH-1:0] data_o
);

   always_comb begin
      data_o = data_i;
      case (mode_i)
         MODE_LSR: data_o = {1'b0, data_i[WIDTH-1:1]};
         MODE_LSL: data_o = {data_i[WIDTH-2:0], 1'b0};
         MODE_ASR: data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
         MODE_ROL: data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
         default:  data_o = data_i;
      endcase
   end

endmodule

// File: rtl/shift_seq.sv
// Multi-bit shift sequencer: accepts an operand, mode and count, applies the
// single-bit shift once per clock `count` times, then holds the result until
// the consumer takes it.
// Ports:
//   clk, rst               clock, async active-low reset
//   in_valid/in_ready      request handshake
//   in_data/in_mode/in_count  operand, {s1,s0} mode, number of steps
//   out_valid/out_ready    result handshake
//   out_data               shifted result (working register)
//   busy                   high while in SHIFT or HOLD
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a request; in_ready high (after first clock)
// ST_SHIFT | one step per cycle, down-counting the remaining steps
// ST_HOLD  | result presented on out_data until out_ready
module shift_seq
   import shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   input  logic [CNT_W-1:0] in_count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [1:0]       mode_q, mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_ready_q, in_ready_d;
   logic [WIDTH-1:0] step_data;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .data_i (work_q),
      .mode_i (mode_q),
      .data_o (step_data)
   );

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               work_d  = in_data;
               mode_d  = in_mode;
               cnt_d   = in_count;
               state_d = (in_count == '0) ? ST_HOLD : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            work_d = step_data;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Registered so it stays low through reset and the first clock after,
      // and so a HOLD->IDLE release can never double as an accept.
      in_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         work_q     <= '0;
         mode_q     <= MODE_LSR;
         cnt_q      <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         work_q     <= work_d;
         mode_q     <= mode_d;
         cnt_q      <= cnt_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q == ST_HOLD);
   assign out_data  = work_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
